// File: rtl/scratch_write_addr_gen.sv
// scratch_write_addr_gen: writes filter and IF cells into their scratchpads; IF side is a circular buffer freed by if_release.
// Optional SCRATCH_RELEASE_CHECK_EN enables the sticky release_err over-release flag.
module scratch_write_addr_gen #(
  parameter int IF_CELL_SIZE = 8,
  parameter int IF_ADDRESS_SIZE = 8,
  parameter int FILTER_CELL_SIZE = 8,
  parameter int FILTER_ADDRESS_SIZE = 8,
  parameter int STRIDE_SIZE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2:0]                   filter_size,
  input  logic [STRIDE_SIZE:0]         stride,
  input  logic [FILTER_CELL_SIZE-1:0]  filt_in_data,
  input  logic                         filt_in_valid,
  output logic                         filt_in_ready,
  input  logic [IF_CELL_SIZE-1:0]      if_in_data,
  input  logic                         if_in_valid,
  input  logic                         if_in_last,
  output logic                         if_in_ready,
  input  logic                         if_release,
  output logic                         write_cnt_filter,
  output logic [FILTER_ADDRESS_SIZE:0] write_addr_filter,
  output logic [FILTER_CELL_SIZE-1:0]  write_data_filter,
  output logic                         write_cnt_if,
  output logic [IF_ADDRESS_SIZE:0]     write_addr_if,
  output logic [IF_CELL_SIZE-1:0]      write_data_if,
  output logic                         fill_done,
  output logic                         release_err
);
  typedef enum logic [1:0] {IDLE, LOAD_FILT, STREAM_IF, DONE} state_t;
  state_t state;
  logic [2:0] fs_q;
  logic [FILTER_ADDRESS_SIZE-1:0] filt_ptr;
  logic [IF_ADDRESS_SIZE:0] if_ptr, occ, occ_n;
  logic [IF_ADDRESS_SIZE+1:0] sum, sub;
  logic filt_xfer, if_xfer, filt_last, over, idle_start;
  always_comb begin
    filt_xfer = filt_in_valid & filt_in_ready;
    if_xfer = if_in_valid & if_in_ready;
    filt_last = filt_ptr == FILTER_ADDRESS_SIZE'(fs_q - 3'd1);
    idle_start = start && (state == IDLE || state == DONE);
    sum = {1'b0, occ} + (IF_ADDRESS_SIZE+2)'(if_xfer);
    sub = (if_release && state != IDLE) ? (IF_ADDRESS_SIZE+2)'(stride) : '0;
    over = sub > sum;
    occ_n = over ? '0 : (IF_ADDRESS_SIZE+1)'(sum - sub);
  end
  // if_ptr is {wrap, index}: its natural overflow toggles the wrap bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fs_q <= '0;
      filt_ptr <= '0;
      if_ptr <= '0;
      occ <= '0;
      filt_in_ready <= 1'b0;
      if_in_ready <= 1'b0;
      write_cnt_filter <= 1'b0;
      write_addr_filter <= '0;
      write_data_filter <= '0;
      write_cnt_if <= 1'b0;
      write_addr_if <= '0;
      write_data_if <= '0;
      fill_done <= 1'b0;
    end else begin
      write_cnt_filter <= filt_xfer;
      write_cnt_if <= if_xfer;
      if (filt_xfer) begin
        write_addr_filter <= {1'b0, filt_ptr};
        write_data_filter <= filt_in_data;
        filt_ptr <= filt_ptr + 1'b1;
      end
      if (if_xfer) begin
        write_addr_if <= if_ptr;
        write_data_if <= if_in_data;
        if_ptr <= if_ptr + 1'b1;
      end
      occ <= occ_n;
      case (state)
        IDLE, DONE: if (start) begin
          fill_done <= 1'b0;
          filt_ptr <= '0;
          if_ptr <= '0;
          occ <= '0;
          fs_q <= filter_size;
          state <= (filter_size == 3'd0) ? STREAM_IF : LOAD_FILT;
          filt_in_ready <= filter_size != 3'd0;
        end
        LOAD_FILT: if (filt_xfer && filt_last) begin
          state <= STREAM_IF;
          filt_in_ready <= 1'b0;
        end
        STREAM_IF: if (if_xfer && if_in_last) begin
          state <= DONE;
          fill_done <= 1'b1;
          if_in_ready <= 1'b0;
        end else if_in_ready <= ~occ_n[IF_ADDRESS_SIZE];
        default: state <= IDLE;
      endcase
    end
  end
`ifdef SCRATCH_RELEASE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) release_err <= 1'b0;
    else if (idle_start) release_err <= 1'b0;
    else if (over) release_err <= 1'b1;
  end
`else
  assign release_err = 1'b0;
`endif
endmodule

// File: tb/tb_scratch_write_addr_gen.sv
// tb_scratch_write_addr_gen: scoreboard bench for scratch_write_addr_gen with a 4-deep IF scratchpad.
module tb_scratch_write_addr_gen;
  logic clk = 0, rst = 1, start = 0, if_release = 0;
  logic [2:0] filter_size = 0, stride = 0;
  logic [7:0] filt_in_data = 0, if_in_data = 0;
  logic filt_in_valid = 0, if_in_valid = 0, if_in_last = 0;
  logic filt_in_ready, if_in_ready, write_cnt_filter, write_cnt_if, fill_done, release_err;
  logic [8:0] write_addr_filter;
  logic [7:0] write_data_filter, write_data_if;
  logic [2:0] write_addr_if;
  int vectors = 0, miscompares = 0;
  logic [31:0] fq[$], iq[$];
  logic exp_err;

  scratch_write_addr_gen #(.IF_ADDRESS_SIZE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .filter_size(filter_size), .stride(stride),
    .filt_in_data(filt_in_data), .filt_in_valid(filt_in_valid), .filt_in_ready(filt_in_ready),
    .if_in_data(if_in_data), .if_in_valid(if_in_valid), .if_in_last(if_in_last), .if_in_ready(if_in_ready),
    .if_release(if_release), .write_cnt_filter(write_cnt_filter), .write_addr_filter(write_addr_filter),
    .write_data_filter(write_data_filter), .write_cnt_if(write_cnt_if), .write_addr_if(write_addr_if),
    .write_data_if(write_data_if), .fill_done(fill_done), .release_err(release_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (write_cnt_filter) begin
      if (fq.size() == 0) chk("filt_extra_pulse", 1, 0);
      else begin
        e = fq.pop_front();
        chk("filt_addr", 32'(write_addr_filter), {16'h0, e[31:16]});
        chk("filt_data", 32'(write_data_filter), {16'h0, e[15:0]});
      end
    end
    if (write_cnt_if) begin
      if (iq.size() == 0) chk("if_extra_pulse", 1, 0);
      else begin
        e = iq.pop_front();
        chk("if_addr", 32'(write_addr_if), {16'h0, e[31:16]});
        chk("if_data", 32'(write_data_if), {16'h0, e[15:0]});
      end
    end
  end

  task automatic do_start(input logic [2:0] fs);
    filter_size = fs; start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic send_filt(input logic [7:0] d, input logic [8:0] a);
    int n = 0;
    filt_in_data = d; filt_in_valid = 1;
    while (!filt_in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("filt_ready_timeout", 0, 1);
    else fq.push_back({16'(a), 16'(d)});
    @(negedge clk) filt_in_valid = 0;
  endtask

  task automatic send_if(input logic [7:0] d, input logic last, input logic [2:0] a);
    int n = 0;
    if_in_data = d; if_in_last = last; if_in_valid = 1;
    while (!if_in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("if_ready_timeout", 0, 1);
    else iq.push_back({16'(a), 16'(d)});
    @(negedge clk) begin if_in_valid = 0; if_in_last = 0; end
  endtask

  task automatic rel(input logic [2:0] s);
    stride = s; if_release = 1;
    @(negedge clk) if_release = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {write_cnt_filter, write_cnt_if, filt_in_ready, if_in_ready, fill_done, release_err}, 0);
    chk({tag, "_addr_f"}, 32'(write_addr_filter), 0);
    chk({tag, "_addr_i"}, 32'(write_addr_if), 0);
    chk({tag, "_data"}, {write_data_filter, write_data_if}, 0);
  endtask

  initial begin
`ifdef SCRATCH_RELEASE_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);
    do_start(3);
    send_filt(8'hA0, 0);
    send_filt(8'hA1, 1);
    send_filt(8'hA2, 2);
    chk("filt_ready_after_load", filt_in_ready, 0);
    chk("if_ready_first_stream", if_in_ready, 0);
    @(negedge clk);
    chk("if_ready_stream", if_in_ready, 1);
    for (int i = 0; i < 4; i++) send_if(8'h10 + 8'(i), 0, 3'(i));
    chk("full_ready", if_in_ready, 0);
    repeat (3) @(negedge clk);
    chk("full_ready_held", if_in_ready, 0);
    rel(1);
    chk("reopen_after_release", if_in_ready, 1);
    send_if(8'h14, 0, 3'd4);
    chk("full_again", if_in_ready, 0);
    rel(1);
    stride = 2; if_release = 1;
    send_if(8'h15, 0, 3'd5);
    if_release = 0;
    chk("ready_after_simul", if_in_ready, 1);
    send_if(8'h16, 0, 3'd6);
    chk("ready_occ3", if_in_ready, 1);
    send_if(8'h17, 0, 3'd7);
    chk("full_occ4", if_in_ready, 0);
    rel(3);
    chk("no_err_legal_release", release_err, 0);
    send_if(8'h18, 1, 3'd0);
    chk("fill_done_pass1", fill_done, 1);
    chk("done_ready", if_in_ready, 0);
    rel(1);
    rel(3);
    chk("release_err", release_err, exp_err);
    repeat (2) @(negedge clk);
    chk("fill_done_held", fill_done, 1);
    do_start(0);
    chk("fill_done_cleared", fill_done, 0);
    chk("release_err_cleared", release_err, 0);
    chk("skip_filt_ready", filt_in_ready, 0);
    send_if(8'h20, 0, 3'd0);
    send_if(8'h21, 1, 3'd1);
    chk("fill_done_pass2", fill_done, 1);
    repeat (3) @(negedge clk);
    chk("fill_done_held2", fill_done, 1);
    do_start(2);
    send_filt(8'hB0, 0);
    do_start(0);
    chk("start_ignored_load", filt_in_ready, 1);
    #1 rst = 1;
    #1 chk_zero("midpass_rst");
    @(negedge clk) rst = 0;
    @(negedge clk);
    do_start(1);
    send_filt(8'hC0, 0);
    send_if(8'h30, 1, 3'd0);
    chk("fill_done_pass3", fill_done, 1);
    repeat (3) @(negedge clk);
    chk("filt_queue_drained", fq.size(), 0);
    chk("if_queue_drained", iq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
